alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between two requesters in the execute stage: port 0 is the main pipeline and port 1 is the auxiliary unit, e.g. address generation or a multi-cycle helper. Each cycle it grants at most one valid request and drives that request's operands and control into the ALU. It captures the result, zero flag and tag into a per-port response register. Each port has independent valid/ready request and response handshakes; latency is one cycle from acceptance to response.

## Interface
- `TAG_WIDTH`, default 4: width of the opaque tag carried from request to response.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `req_valid[1:0]` in 2: request present, per port.
- `req_ready[1:0]` out 2: request accepted this cycle when valid and ready are both high.
- `req_control[i]` in 4 each: ALU op code (`alu_op_t` from `common`).
- `req_left[i]`, `req_right[i]` in 32 each: operands.
- `req_tag[i]` in TAG_WIDTH each: tag, echoed on the response.
- `rsp_valid[1:0]` out 2: response held, per port.
- `rsp_ready[1:0]` in 2: consumer takes the response.
- `rsp_result[i]` out 32 each: registered ALU result.
- `rsp_zero[i]` out 1 each: registered ALU zero flag.
- `rsp_tag[i]` out TAG_WIDTH each: echoed tag.

## Operation
- Port i is eligible when `req_valid[i]` is high and its slot is free: `!rsp_valid[i] || rsp_ready[i]`.
- Exactly one eligible port is granted per cycle.
  - If neither port is eligible, there is no grant.
  - With `ALU_ARB_RR_EN`, the tie-break uses `last_grant`; see Configuration.
- `req_ready[i]` = grant[i]. It is combinational and may depend on `rsp_ready[i]` in the same cycle.
- ALU inputs come from a mux on the granted port. With no grant, the mux selects port 0 inputs (don't-care, no state change).
- On acceptance for port i at edge N:
  - `rsp_result[i]` and `rsp_zero[i]` load the ALU outputs.
  - `rsp_tag[i]` loads `req_tag[i]`.
  - `rsp_valid[i]` is set.
- Response slot update per port:
  - Accept this cycle: set, regardless of `rsp_ready`.
  - Else if `rsp_ready[i]` is high: clear.
  - Else: hold, with data stable.
- Response data must not change while `rsp_valid[i]` is high and `rsp_ready[i]` is low.
- Op codes are passed through unmodified. Undefined codes behave as the ALU default (ADD).
- Arithmetic and width behaviour are exactly the ALU's. The arbiter never alters operands.

## Timing
- Latency: request accepted at edge N; response visible after edge N; earliest consumption at edge N+1.
- Throughput: one accept per cycle total across both ports. One port alone sustains 1/cycle when its `rsp_ready` is held high.
- Reset values, with `reset_n` low at an edge:
  - `rsp_valid` = 0; `rsp_result`, `rsp_zero`, `rsp_tag` = 0.
  - `last_grant` = 1, so port 0 wins the first contention.
- `req_ready` is forced 0 while `reset_n` is low.
- Reset mid-operation: pending responses are discarded, not delivered. Requests presented during the reset cycle are not accepted.
- Simultaneous consume and accept on one port: the new result replaces the old one at the same edge; `rsp_valid` stays 1.
- Stalled port: a port whose slot is full and not being drained is ineligible. The other port may be granted in the same cycle, so there is no head-of-line blocking.
- Rotation: `last_grant` updates only on an actual grant.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are eligible, grant the port that is not `last_grant`.
  - Starvation bound: one cycle.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins.
  - The `last_grant` register is not built.
  - Port 1 may starve under continuous port 0 traffic.

## Structure
- Package `common` holds:
  - the existing `alu_op_t` codes;
  - `alu_req_t` (control, left, right, tag);
  - `alu_rsp_t` (result, zero, tag).
- Sub-module: one `alu` instance. Grant logic, input mux and response registers live in `alu_arbiter`.

## Test plan
- Single ADD: port 0 sends `ALU_ADD`, left 5, right 7, tag 3, `rsp_ready` high → next cycle `rsp_valid[0]`=1, result 12, zero 0, tag 3; port 1 idle.
- Contention (RR build): both ports valid every cycle, both `rsp_ready` high; port 0 sends `ALU_SUB` 9−9, port 1 sends `ALU_SLT` −1 vs 1 → grants alternate 0,1,0,1. Port 0 responses are result 0 with zero 1; port 1 responses are result 1.
- Backpressure: port 1 sends `ALU_SRA` 0x80000000 by 4 with `rsp_ready[1]` low for 3 cycles → response 0xF8000000 is held stable and `req_ready[1]`=0. Port 0 meanwhile streams `ALU_XOR` requests accepted every cycle.
- Accept while draining: port 0 has a full slot, `rsp_ready[0]`=1 and a new `ALU_SLL` 1<<31 request → accepted the same cycle. The old response is consumed and the next cycle shows 0x80000000 with valid still 1.
- Reset mid-operation: both slots full, `reset_n` low for one edge → `rsp_valid`=00, outputs 0. The first post-reset contention grants port 0.
- Fixed-priority build: both ports continuously valid → port 0 always granted and port 1 never accepted. Dropping `req_valid[0]` → port 1 accepted next cycle.

Source files
------------

// File: rtl/common.sv
// ALU op codes and the request/response records exchanged with the shared execute-stage ALU.
package common;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   // Widest tag any arbiter instance may carry; narrower tags are zero-extended.
   localparam int unsigned ALU_TAG_MAX_W = 16;

   typedef struct packed {
      logic [3:0]               control;
      logic [31:0]              left;
      logic [31:0]              right;
      logic [ALU_TAG_MAX_W-1:0] tag;
   } alu_req_t;

   typedef struct packed {
      logic [31:0]              result;
      logic                     zero;
      logic [ALU_TAG_MAX_W-1:0] tag;
   } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown op codes fall back to ADD.
module alu
   import common::*;
(
   input  logic [3:0]  control,
   input  logic [31:0] left,
   input  logic [31:0] right,
   output logic [31:0] result,
   output logic        zero
);

   logic [4:0] shamt;
   assign shamt = right[4:0];

   always_comb begin
      result = left + right;
      case (control)
         ALU_SUB:  result = left - right;
         ALU_SLL:  result = left << shamt;
         ALU_SLT:  result = {31'd0, $signed(left) < $signed(right)};
         ALU_SLTU: result = {31'd0, left < right};
         ALU_XOR:  result = left ^ right;
         ALU_SRL:  result = left >> shamt;
         ALU_SRA:  result = $unsigned($signed(left) >>> shamt);
         ALU_OR:   result = left | right;
         ALU_AND:  result = left & right;
         default:  result = left + right;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU with a one-deep response slot per port.
// Define ALU_ARB_RR_EN for round-robin tie-break; default is fixed priority to port 0.
module alu_arbiter
   import common::*;
#(
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0][3:0]           req_control,
   input  logic [1:0][31:0]          req_left,
   input  logic [1:0][31:0]          req_right,
   input  logic [1:0][TAG_WIDTH-1:0] req_tag,
   output logic [1:0]                rsp_valid,
   input  logic [1:0]                rsp_ready,
   output logic [1:0][31:0]          rsp_result,
   output logic [1:0]                rsp_zero,
   output logic [1:0][TAG_WIDTH-1:0] rsp_tag
);

   alu_req_t [1:0] req;
   alu_rsp_t [1:0] rsp_d, rsp_q;
   logic     [1:0] rsp_valid_d, rsp_valid_q;
   logic     [1:0] elig, gnt;
   logic     [3:0] alu_control;
   logic    [31:0] alu_left, alu_right, alu_result;
   logic           alu_zero;
   logic           unused_rsp_tag;

   // A port can take a new request only if its slot is empty or drains this cycle.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         req[i].control = req_control[i];
         req[i].left    = req_left[i];
         req[i].right   = req_right[i];
         req[i].tag     = ALU_TAG_MAX_W'(req_tag[i]);
         elig[i]        = reset_n && req_valid[i] && (!rsp_valid_q[i] || rsp_ready[i]);
      end
   end

`ifdef ALU_ARB_RR_EN
   logic last_grant_d, last_grant_q;

   always_comb begin
      if (&elig) gnt = last_grant_q ? 2'b01 : 2'b10;
      else       gnt = elig;
      last_grant_d = (|gnt) ? gnt[1] : last_grant_q;
   end

   // Reset to port 1 so port 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!reset_n) last_grant_q <= 1'b1;
      else          last_grant_q <= last_grant_d;
   end
`else
   always_comb begin
      gnt = {elig[1] & ~elig[0], elig[0]};
   end
`endif

   assign req_ready = gnt;

   always_comb begin
      alu_control = gnt[1] ? req[1].control : req[0].control;
      alu_left    = gnt[1] ? req[1].left    : req[0].left;
      alu_right   = gnt[1] ? req[1].right   : req[0].right;
   end

   alu u_alu (
      .control (alu_control),
      .left    (alu_left),
      .right   (alu_right),
      .result  (alu_result),
      .zero    (alu_zero)
   );

   // An accept overrides a same-cycle drain so the slot stays full with the new result.
   always_comb begin
      rsp_d       = rsp_q;
      rsp_valid_d = rsp_valid_q;
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) begin
            rsp_valid_d[i]  = 1'b1;
            rsp_d[i].result = alu_result;
            rsp_d[i].zero   = alu_zero;
            rsp_d[i].tag    = req[i].tag;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_q       <= '0;
         rsp_valid_q <= '0;
      end else begin
         rsp_q       <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rsp_result[i] = rsp_q[i].result;
         rsp_zero[i]   = rsp_q[i].zero;
         rsp_tag[i]    = rsp_q[i].tag[TAG_WIDTH-1:0];
      end
   end

   assign rsp_valid      = rsp_valid_q;
   assign unused_rsp_tag = ^{rsp_q[0].tag, rsp_q[1].tag};

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
   import common::*;

   localparam int TW = 4;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset_n;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0][3:0]     req_control;
   logic [1:0][31:0]    req_left;
   logic [1:0][31:0]    req_right;
   logic [1:0][TW-1:0]  req_tag;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [1:0][31:0]    rsp_result;
   logic [1:0]          rsp_zero;
   logic [1:0][TW-1:0]  rsp_tag;

   alu_arbiter #(.TAG_WIDTH(TW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_control (req_control),
      .req_left    (req_left),
      .req_right   (req_right),
      .req_tag     (req_tag),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_tag     (rsp_tag)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: what each response slot should hold, and who won last.
   bit            m_valid [2];
   bit            m_known [2];
   logic [31:0]   m_result[2];
   bit            m_zero  [2];
   logic [TW-1:0] m_tag   [2];
   int            m_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      logic [31:0] r;
      sh = int'(b % 32);
      case (op)
         ALU_SUB:  r = a - b;
         ALU_SLL:  r = a << sh;
         ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  r = a ^ b;
         ALU_SRL:  r = a >> sh;
         ALU_SRA:  begin
            r = a >> sh;
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
         end
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         default:  r = a + b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i]  = 1'b0;
         m_known[i]  = 1'b1;
         m_result[i] = '0;
         m_zero[i]   = 1'b0;
         m_tag[i]    = '0;
      end
      m_last = 1;
   endtask

   task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] l,
                          input logic [31:0] r, input logic [TW-1:0] t);
      req_control[p] = op;
      req_left[p]    = l;
      req_right[p]   = r;
      req_tag[p]     = t;
   endtask

   // Called just after a falling edge with inputs settled; returns at the next falling edge.
   task automatic run_cycle();
      bit         e[2];
      int         win;
      logic [1:0] exp_ready;
      #1;
      for (int i = 0; i < 2; i++)
         e[i] = reset_n && req_valid[i] && (!m_valid[i] || rsp_ready[i]);
      if (e[0] && e[1])  win = RR ? 1 - m_last : 0;
      else if (e[0])     win = 0;
      else if (e[1])     win = 1;
      else               win = -1;
      exp_ready = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
      check("req_ready", req_ready, exp_ready);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rsp_valid%0d", i), rsp_valid[i], m_valid[i]);
         if (m_known[i]) begin
            check($sformatf("rsp_result%0d", i), rsp_result[i], m_result[i]);
            check($sformatf("rsp_zero%0d", i), rsp_zero[i], m_zero[i]);
            check($sformatf("rsp_tag%0d", i), rsp_tag[i], m_tag[i]);
         end
      end
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i == win) begin
               m_valid[i]  = 1'b1;
               m_known[i]  = 1'b1;
               m_result[i] = alu_ref(req_control[i], req_left[i], req_right[i]);
               m_zero[i]   = (m_result[i] == 32'd0);
               m_tag[i]    = req_tag[i];
            end else if (rsp_ready[i]) begin
               m_valid[i] = 1'b0;
               m_known[i] = 1'b0;
            end
         end
         if (win >= 0) m_last = win;
      end
      @(negedge clk);
   endtask

   initial begin
      reset_n     = 1'b0;
      req_valid   = 2'b00;
      rsp_ready   = 2'b00;
      req_control = '0;
      req_left    = '0;
      req_right   = '0;
      req_tag     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();

      // Requests during reset must not be accepted.
      req_valid = 2'b11;
      run_cycle();
      reset_n = 1'b1;

      // Single ADD on port 0.
      req_valid = 2'b01;
      rsp_ready = 2'b11;
      set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd3);
      run_cycle();
      req_valid = 2'b00;
      check("add_result", rsp_result[0], 32'd12);
      check("add_tag", rsp_tag[0], 4'd3);
      run_cycle();

      // Contention with both consumers ready.
      req_valid = 2'b11;
      for (int c = 0; c < 4; c++) begin
         set_req(0, ALU_SUB, 32'd9, 32'd9, TW'(c));
         set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, TW'(c + 8));
         run_cycle();
      end
      req_valid = 2'b00;
      run_cycle();

      // Backpressure on port 1 while port 0 streams XORs.
      req_valid = 2'b10;
      rsp_ready = 2'b01;
      set_req(1, ALU_SRA, 32'h8000_0000, 32'd4, 4'd5);
      run_cycle();
      req_valid = 2'b11;
      set_req(1, ALU_ADD, 32'd1, 32'd1, 4'd6);
      for (int c = 0; c < 3; c++) begin
         check("bp_hold", rsp_result[1], 32'hF800_0000);
         set_req(0, ALU_XOR, $urandom, $urandom, TW'(c));
         run_cycle();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      run_cycle();

      // Accept while draining on port 0.
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      set_req(0, ALU_ADD, 32'd1, 32'd1, 4'd1);
      run_cycle();
      rsp_ready = 2'b01;
      set_req(0, ALU_SLL, 32'd1, 32'd31, 4'd2);
      run_cycle();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      check("drain_valid", rsp_valid[0], 1'b1);
      check("drain_result", rsp_result[0], 32'h8000_0000);
      run_cycle();

      // Reset with both slots full.
      req_valid = 2'b10;
      set_req(1, ALU_OR, 32'hF0, 32'h0F, 4'd9);
      run_cycle();
      reset_n   = 1'b0;
      req_valid = 2'b11;
      run_cycle();
      reset_n = 1'b1;
      check("rst_valid", rsp_valid, 2'b00);
      check("rst_result1", rsp_result[1], 32'd0);
      rsp_ready = 2'b11;
      set_req(0, ALU_AND, 32'hFF, 32'h0F, 4'd4);
      set_req(1, ALU_SUB, 32'd3, 32'd1, 4'd7);
      #1;
      check("rst_first_grant", req_ready, 2'b01);
      for (int c = 0; c < 4; c++) run_cycle();

      // Drop port 0 while port 1 keeps asking.
      req_valid = 2'b10;
      run_cycle();
      req_valid = 2'b00;
      run_cycle();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < 2; p++) begin
            set_req(p, 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), TW'($urandom));
            req_valid[p] = ($urandom_range(0, 3) != 0);
            rsp_ready[p] = ($urandom_range(0, 2) != 0);
         end
         reset_n = ($urandom_range(0, 80) != 0);
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
